// File: rtl/ram_skew_feeder.sv
// ============================================================================
// Module   : ram_skew_feeder
// Purpose  : Issues strided row reads to one operand-RAM port and skews lane i
//            by i cycles so rows enter the systolic array diagonally.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_skew_feeder #(
    parameter int DESIGN_SIZE = 8,
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 10,
    parameter int CWIDTH      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [AWIDTH-1:0]               base_addr,
    input  logic [AWIDTH-1:0]               stride,
    input  logic [CWIDTH-1:0]               num_rows,
    output logic [AWIDTH-1:0]               ram_addr,
    output logic [DESIGN_SIZE-1:0]          ram_we,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   ram_q,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   a_data,
    output logic [DESIGN_SIZE-1:0]          a_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int DCW = $clog2(DESIGN_SIZE + 1);
    localparam logic [DCW-1:0] C_DRAIN_LAST = DCW'(DESIGN_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CWIDTH-1:0]   r_row_cnt;
    logic [CWIDTH-1:0]   r_num_m1;
    logic [AWIDTH-1:0]   r_addr;
    logic [AWIDTH-1:0]   r_stride;
    logic [DCW-1:0]      r_drain_cnt;
    logic                r_zero_run;
    logic                r_v0;
    logic                w_last_row;

    // Comparing against N-1 lets N = 2^CWIDTH-1 run without a wider counter.
    assign w_last_row = (r_row_cnt == r_num_m1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_rows == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_last_row) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == C_DRAIN_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_num_m1    <= '0;
            r_addr      <= '0;
            r_stride    <= '0;
            r_drain_cnt <= '0;
            r_zero_run  <= 1'b0;
            r_v0        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_v0    <= (r_state == S_READ);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stride    <= stride;
                        r_num_m1    <= num_rows - 1'b1;
                        r_row_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_zero_run  <= (num_rows == '0);
                        // An empty request leaves the last issued address on the bus.
                        if (num_rows != '0) begin
                            r_addr <= base_addr;
                        end
                    end
                end
                S_READ: begin
                    if (!w_last_row) begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                        r_addr    <= r_addr + r_stride;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                end
                S_DONE: begin
                    r_zero_run <= 1'b0;
                end
                default: begin
                    r_zero_run <= 1'b0;
                end
            endcase
        end
    end

    assign ram_addr = r_addr;
    assign ram_we   = '0;
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state == S_READ) || (r_state == S_DRAIN) ||
                      ((r_state == S_DONE) && r_zero_run);

    for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
        logic [DWIDTH-1:0] w_lane_d;
        logic              w_lane_v;

        if (i == 0) begin : g_direct
            // ram_q is already a registered RAM output; lane 0 needs no extra stage.
            assign w_lane_d = ram_q[DWIDTH-1:0];
            assign w_lane_v = r_v0;
        end else begin : g_skew
            logic [DWIDTH-1:0] r_sd [0:i-1];
            logic [i-1:0]      r_sv;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < i; j++) begin
                        r_sd[j] <= '0;
                    end
                    r_sv <= '0;
                end else begin
                    r_sd[0] <= ram_q[i*DWIDTH +: DWIDTH];
                    r_sv[0] <= r_v0;
                    for (int j = 1; j < i; j++) begin
                        r_sd[j] <= r_sd[j-1];
                        r_sv[j] <= r_sv[j-1];
                    end
                end
            end

            assign w_lane_d = r_sd[i-1];
            assign w_lane_v = r_sv[i-1];
        end

        assign a_data[i*DWIDTH +: DWIDTH] = w_lane_v ? w_lane_d : '0;
        assign a_valid[i]                 = w_lane_v;
    end

endmodule

`default_nettype wire
